// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART receive/transmit front ends:
//               FSM state encoding, oversampling constants, majority voter.
//               Optional macro UART_RX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_OVERSAMPLE  = 16;
    localparam int c_SAMPLE_MID  = 9;
    localparam int c_LAST_SAMPLE = 15;

`ifdef UART_RX_PARITY_EN
    localparam int c_STATE_W = 3;
`else
    localparam int c_STATE_W = 2;
`endif

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = c_STATE_W'(0);
    localparam logic [c_STATE_W-1:0] c_ST_START = c_STATE_W'(1);
    localparam logic [c_STATE_W-1:0] c_ST_DATA  = c_STATE_W'(2);
    localparam logic [c_STATE_W-1:0] c_ST_STOP  = c_STATE_W'(3);
`ifdef UART_RX_PARITY_EN
    localparam logic [c_STATE_W-1:0] c_ST_PARITY = c_STATE_W'(4);
`endif

    // Majority of three samples
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick_gen
// Description : Oversample tick generator. Emits a one-cycle tick every
//               max(div,1) PCLK cycles; clr restarts the count so the tick
//               phase can be aligned to an external event.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [DIV_WIDTH-1:0] w_div_max;

    // Terminal count; a divisor of zero behaves as one
    always_comb begin
        w_div_max = '0;
        if (div != '0) begin
            w_div_max = div - DIV_WIDTH'(1);
        end
    end

    // >= so a divisor lowered mid-count wraps at once instead of overrunning
    assign tick = (r_div_cnt >= w_div_max);

    // Divider counter, restarted by reset or clr
    always_ff @(posedge PCLK) begin
        if (PRESET || clr) begin
            r_div_cnt <= '0;
        end else if (tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampler
// Description : UART receive front end. 2-FF input synchronizer, falling-edge
//               start detection, 16x oversampling with a 3-sample mid-bit
//               majority vote, LSB-first deserialisation, framing check.
//               Macro UART_RX_PARITY_EN adds a parity bit (parity_odd,
//               rx_parity_err) between the data and stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = c_OVERSAMPLE
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 rx_parity_err,
`endif
    input  logic                 rx_en,
    input  logic                 rx_rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 rx_error
);

    localparam int                c_OS_W     = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_OS_FIRST = c_OS_W'(c_SAMPLE_MID - 2);
    localparam logic [c_OS_W-1:0] c_OS_MID   = c_OS_W'(c_SAMPLE_MID);
    localparam logic [c_OS_W-1:0] c_OS_LAST  = c_OS_W'(c_LAST_SAMPLE);
    localparam logic [3:0]        c_BIT_LAST = 4'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [c_STATE_W-1:0] c_ST_AFTER_DATA = c_ST_PARITY;
`else
    localparam logic [c_STATE_W-1:0] c_ST_AFTER_DATA = c_ST_STOP;
`endif

    logic                 r_sync_0;
    logic                 r_rx_s;
    logic                 r_rx_s_d;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_OS_W-1:0]    r_os_cnt;
    logic [3:0]           r_bit_cnt;
    logic [1:0]           r_vote;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_error;
    logic                 w_tick;
    logic                 w_start_det;
    logic                 w_mid;
    logic                 w_last;
    logic                 w_window;
    logic                 w_bit;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_err;
`endif

    // Oversample tick source; restarted at the start edge for phase alignment
    uart_baud_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (rx_rst || w_start_det),
        .div    (baud_div),
        .tick   (w_tick)
    );

    // Two-flop synchronizer plus one delay stage for edge detection; idles high
    always_ff @(posedge PCLK) begin
        if (PRESET || rx_rst) begin
            r_sync_0 <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync_0 <= rx_serial;
            r_rx_s   <= r_sync_0;
            r_rx_s_d <= r_rx_s;
        end
    end

    // The vote register keeps samples 7 and 8; sample 9 is the live rx_s,
    // so the bit decision is ready on the mid-bit tick itself
    assign w_bit    = maj3({r_vote, r_rx_s});
    assign w_mid    = w_tick && (r_os_cnt == c_OS_MID);
    assign w_last   = w_tick && (r_os_cnt == c_OS_LAST);
    assign w_window = w_tick && (r_os_cnt >= c_OS_FIRST) && (r_os_cnt < c_OS_MID);

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET || rx_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and start detection
    always_comb begin
        w_state_nxt = r_state;
        w_start_det = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_en && r_rx_s_d && !r_rx_s) begin
                    w_start_det = 1'b1;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_mid && w_bit) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_last && (r_bit_cnt == c_BIT_LAST)) begin
                    w_state_nxt = c_ST_AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_last) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
`endif
            c_ST_STOP: begin
                // Leaving at mid stop bit leaves half a bit of slack for the next start
                if (w_mid) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        // Disabling the receiver aborts any frame in progress
        if (!rx_en) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Counters, vote window, shift register and status outputs
    always_ff @(posedge PCLK) begin
        if (PRESET || rx_rst) begin
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_vote       <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_start_det) begin
                r_os_cnt     <= '0;
                r_bit_cnt    <= '0;
                r_error      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + c_OS_W'(1);
            end

            if (w_window) begin
                r_vote <= {r_vote[0], r_rx_s};
            end

            // Gated by rx_en so an abort in the same cycle never completes a frame
            if (rx_en) begin
                if ((r_state == c_ST_DATA) && w_mid) begin
                    r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                end
                if ((r_state == c_ST_DATA) && w_last && (r_bit_cnt != c_BIT_LAST)) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
`ifdef UART_RX_PARITY_EN
                if ((r_state == c_ST_PARITY) && w_mid) begin
                    if (w_bit != ((^r_shift) ^ parity_odd)) begin
                        r_parity_err <= 1'b1;
                    end
                end
`endif
                if ((r_state == c_ST_STOP) && w_mid) begin
                    if (w_bit) begin
                        r_data <= r_shift;
                        r_done <= 1'b1;
                    end else begin
                        r_error <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_done  = r_done;
    assign rx_busy  = (r_state != c_ST_IDLE);
    assign rx_error = r_error;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire
